// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data memory port seen by dmem_arbiter.
// The slave modport is the arbiter; master is the surrounding requesters and memory.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic          lock0;
    logic          lock1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_rd,
        output gnt0, gnt1, rdata0, rdata1, mem_a, mem_we, mem_wd
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_rd,
        input  gnt0, gnt1, rdata0, rdata1, mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the processor
// (port 0) and a second master (port 1), with bounded locked ownership and a stall counter.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_arbiter_if.slave         bus,
    output logic [15:0]           stall_cnt
);
    localparam int HW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   stallCnt_q, stallCnt_d;
    logic          gnt0, gnt1;
    logic          forceRel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            hold_q     <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // A full hold count turns the owner's cycle into an arbitration cycle won by the waiter.
    assign forceRel = (hold_q == HW'(MAX_LOCK));

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        last_d     = last_q;
        hold_d     = hold_q;
        stallCnt_d = stallCnt_q;

        unique case (state_q)
            ARB: begin
                if (bus.req0 && bus.req1) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = bus.req0;
                    gnt1 = bus.req1;
                end
            end
            OWN0: begin
                if (bus.req1 && forceRel) gnt1 = 1'b1;
                else                      gnt0 = bus.req0;
            end
            OWN1: begin
                if (bus.req0 && forceRel) gnt0 = 1'b1;
                else                      gnt1 = bus.req1;
            end
            default: ;
        endcase

        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            last_d  = 1'b0;
            state_d = bus.lock0 ? OWN0 : ARB;
        end else if (gnt1) begin
            last_d  = 1'b1;
            state_d = bus.lock1 ? OWN1 : ARB;
        end else begin
            state_d = ARB;
        end

        if (state_d != state_q)
            hold_d = '0;
        else if (state_q == OWN0 && bus.req1 && !forceRel)
            hold_d = hold_q + HW'(1);
        else if (state_q == OWN1 && bus.req0 && !forceRel)
            hold_d = hold_q + HW'(1);
        else
            hold_d = '0;

        if (bus.req0 && !gnt0 && stallCnt_q != 16'hFFFF)
            stallCnt_d = stallCnt_q + 16'd1;
    end

    // With no grant the memory sees port 0's address and a suppressed write.
    always_comb begin
        if (gnt1) begin
            bus.mem_a  = bus.addr1;
            bus.mem_we = bus.we1;
            bus.mem_wd = bus.wdata1;
        end else begin
            bus.mem_a  = bus.addr0;
            bus.mem_we = bus.we0 & gnt0;
            bus.mem_wd = bus.wdata0;
        end
    end

    assign bus.gnt0   = gnt0;
    assign bus.gnt1   = gnt1;
    assign bus.rdata0 = bus.mem_rd;
    assign bus.rdata1 = bus.mem_rd;
    assign stall_cnt  = stallCnt_q;
endmodule
